weight_loader: RTL and testbench

//   Write-side driver for a layer of per-neuron weight memories.

---
 rtl/neuron_pkg.sv | 10 +
 rtl/weight_loader_if.sv | 26 ++
 rtl/mod_counter.sv | 39 +++
 rtl/weight_loader.sv | 114 +++++++++++
 tb/tb_weight_loader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron layer: weight word and weight-loader FSM states.
package neuron_pkg;

    localparam int unsigned DataBits = 16;

    typedef logic [DataBits-1:0] weight_t;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_e;

endpackage

// File: rtl/weight_loader_if.sv
// Weight stream (valid/ready) plus the shared write port of the layer's weight memories.
interface weight_loader_if #(
    parameter int unsigned data_bits    = 16,
    parameter int unsigned address_bits = 10,
    parameter int unsigned num_neurons  = 30
);

    logic                    s_valid;
    logic [data_bits-1:0]    s_data;
    logic                    s_ready;
    logic [num_neurons-1:0]  write_en;
    logic [address_bits-1:0] write_add;
    logic [data_bits-1:0]    weight_in;

    // Master: stream source and memory-side observer; slave: the loader itself.
    modport master (
        output s_valid, s_data,
        input  s_ready, write_en, write_add, weight_in
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, write_en, write_add, weight_in
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear; wrap flags the enabled step from N-1 back to 0.
module mod_counter #(
    parameter int unsigned width   = 10,
    parameter int unsigned modulus = 784
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [width-1:0] count,
    output logic             wrap
);

    logic [width-1:0] count_q, count_d;
    logic             at_max;

    // Explicit compare so non-power-of-two moduli wrap correctly.
    assign at_max = (count_q == width'(modulus - 1));
    assign wrap   = en && at_max;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_max ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams a full layer of weights, neuron-major, into per-neuron memories via a
// registered one-hot write port.
module weight_loader
    import neuron_pkg::*;
#(
    parameter int unsigned data_bits    = 16,
    parameter int unsigned num_weights  = 784,
    parameter int unsigned address_bits = 10,
    parameter int unsigned num_neurons  = 30,
    parameter int unsigned neuron_bits  = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    weight_loader_if.slave bus
);

    loader_state_e state_q, state_d;

    logic                    s_ready;
    logic                    accept;
    logic                    cnt_clr;
    logic                    addr_wrap;
    logic                    last_beat;
    logic [address_bits-1:0] addr;
    logic [neuron_bits-1:0]  neuron;
    logic [num_neurons-1:0]  neuron_onehot;
    logic [num_neurons-1:0]  write_en_q;
    logic [address_bits-1:0] write_add_q;
    logic [data_bits-1:0]    weight_in_q;

    // Counters only advance in LOAD; leaving LOAD by abort resets the position.
    assign cnt_clr = (state_q != LOAD) || abort;

    mod_counter #(
        .width   (address_bits),
        .modulus (num_weights)
    ) u_addr_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .clr   (cnt_clr),
        .count (addr),
        .wrap  (addr_wrap)
    );

    mod_counter #(
        .width   (neuron_bits),
        .modulus (num_neurons)
    ) u_neuron_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (addr_wrap),
        .clr   (cnt_clr),
        .count (neuron),
        .wrap  (last_beat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready       = (state_q == LOAD) && !abort;
        accept        = bus.s_valid && s_ready;
        busy          = (state_q == LOAD) || (state_q == DONE);
        done          = (state_q == DONE);
        neuron_onehot = num_neurons'(1) << neuron;
    end

    // Write port: strobe for one cycle per accepted beat, address/data hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_en_q  <= '0;
            write_add_q <= '0;
            weight_in_q <= '0;
        end else begin
            write_en_q <= accept ? neuron_onehot : '0;
            if (accept) begin
                write_add_q <= addr;
                weight_in_q <= bus.s_data;
            end
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.write_en  = write_en_q;
    assign bus.write_add = write_add_q;
    assign bus.weight_in = weight_in_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench: a beat-count reference model for a 4x2 loader and a full
// 784x30 load with random valid gaps.
module tb_weight_loader;
    import neuron_pkg::*;

    localparam int unsigned NW        = 4;
    localparam int unsigned NN        = 2;
    localparam int unsigned BIG_NW    = 784;
    localparam int unsigned BIG_NN    = 30;
    localparam int unsigned BIG_TOTAL = BIG_NW * BIG_NN;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic sm_start, sm_abort, sm_busy, sm_done;
    logic bg_start, bg_abort, bg_busy, bg_done;

    weight_loader_if #(.data_bits(16), .address_bits(2),  .num_neurons(2))  s_if ();
    weight_loader_if #(.data_bits(16), .address_bits(10), .num_neurons(30)) b_if ();

    weight_loader #(
        .data_bits    (16),
        .num_weights  (NW),
        .address_bits (2),
        .num_neurons  (NN),
        .neuron_bits  (1)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .start (sm_start),
        .abort (sm_abort),
        .busy  (sm_busy),
        .done  (sm_done),
        .bus   (s_if.slave)
    );

    weight_loader u_big (
        .clk   (clk),
        .reset (reset),
        .start (bg_start),
        .abort (bg_abort),
        .busy  (bg_busy),
        .done  (bg_done),
        .bus   (b_if.slave)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the small loader, in terms of beats accepted so far.
    logic        m_load, m_done;
    int          m_beat;
    logic [1:0]  exp_we;
    logic [1:0]  exp_add;
    weight_t     exp_data;
    weight_t     obs_mem [NN][NW];

    task automatic model_reset();
        m_load = 1'b0; m_done = 1'b0; m_beat = 0;
        exp_we = '0; exp_add = '0; exp_data = '0;
    endtask

    task automatic clear_obs();
        for (int n = 0; n < NN; n++)
            for (int a = 0; a < NW; a++) obs_mem[n][a] = '0;
    endtask

    // One clock of the small DUT; called and returns at posedge+1.
    task automatic step(input logic v, input weight_t d, input logic st, input logic ab);
        logic acc;
        s_if.s_valid = v; s_if.s_data = d; sm_start = st; sm_abort = ab;
        #3;
        check_eq("s_ready", s_if.s_ready, m_load && !ab);
        acc = v && m_load && !ab;
        @(posedge clk); #1;
        if (acc) begin
            exp_we   = 2'(1 << (m_beat / NW));
            exp_add  = 2'(m_beat % NW);
            exp_data = d;
            m_beat++;
        end else begin
            exp_we = '0;
        end
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_load) begin
            if (ab) begin
                m_load = 1'b0; m_beat = 0;
            end else if (m_beat == NW * NN) begin
                m_load = 1'b0; m_done = 1'b1; m_beat = 0;
            end
        end else if (st) begin
            m_load = 1'b1;
        end
        check_eq("write_en",  s_if.write_en,  exp_we);
        check_eq("write_add", s_if.write_add, exp_add);
        check_eq("weight_in", s_if.weight_in, exp_data);
        check_eq("done",      sm_done,        m_done);
        check_eq("busy",      sm_busy,        m_load || m_done);
        if (s_if.write_en == 2'b01) obs_mem[0][s_if.write_add] = s_if.weight_in;
        if (s_if.write_en == 2'b10) obs_mem[1][s_if.write_add] = s_if.weight_in;
    endtask

    task automatic check_mem(input string tag);
        for (int n = 0; n < NN; n++)
            for (int a = 0; a < NW; a++)
                check_eq($sformatf("%s_mem%0d_%0d", tag, n, a), obs_mem[n][a], n * NW + a + 1);
    endtask

    // Big-DUT scoreboard: k-th write must be neuron k/784, address k%784, data of beat k.
    weight_t             bdata [BIG_TOTAL];
    int                  bwrites   = 0;
    int                  bdone_cnt = 0;
    int                  b_errs    = 0;
    logic [BIG_NN-1:0]   exp_oh;

    always @(negedge clk) begin
        if (reset) begin
            if (b_if.write_en != '0) begin
                if (bwrites >= int'(BIG_TOTAL)) begin
                    b_errs++;
                end else begin
                    exp_oh = BIG_NN'(1) << (bwrites / BIG_NW);
                    if (b_if.write_en != exp_oh || b_if.write_add > 10'd783 ||
                        b_if.write_add != 10'(bwrites % BIG_NW) ||
                        b_if.weight_in != bdata[bwrites]) b_errs++;
                end
                bwrites++;
            end
            if (bg_done) begin
                bdone_cnt++;
                if (bwrites != int'(BIG_TOTAL)) b_errs++;
            end
        end
    end

    initial begin
        int bbeats;
        int cyc;
        s_if.s_valid = 1'b0; s_if.s_data = '0; sm_start = 1'b0; sm_abort = 1'b0;
        b_if.s_valid = 1'b0; b_if.s_data = '0; bg_start = 1'b0; bg_abort = 1'b0;
        model_reset();
        clear_obs();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_write_en",  s_if.write_en,  0);
        check_eq("rst_write_add", s_if.write_add, 0);
        check_eq("rst_weight_in", s_if.weight_in, 0);
        check_eq("rst_done",      sm_done,        0);
        check_eq("rst_busy",      sm_busy,        0);
        check_eq("rst_s_ready",   s_if.s_ready,   0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: back-to-back load.
        step(0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
        step(0, 0, 0, 0);
        check_mem("t1");

        // 2: three-cycle gap after beat 2.
        clear_obs();
        step(0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 16'(i), 0, 0);
            if (i == 2) repeat (3) step(0, 16'h5555, 0, 0);
        end
        step(0, 0, 0, 0);
        check_mem("t2");

        // 3: valid while idle is ignored.
        repeat (5) step(1, 16'hBEEF, 0, 0);
        check_eq("idle_write_en", s_if.write_en, 0);

        // 4: abort coincident with beat 3, then a full restart with random data.
        step(0, 0, 1, 0);
        step(1, 16'h0001, 0, 0);
        step(1, 16'h0002, 0, 0);
        step(1, 16'h0003, 0, 1);
        check_eq("abort_busy", sm_busy, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0);
        step(0, 0, 0, 0);

        // 5: asynchronous reset mid-load.
        step(0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) step(1, 16'(i), 0, 0);
        s_if.s_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("arst_write_en",  s_if.write_en,  0);
        check_eq("arst_write_add", s_if.write_add, 0);
        check_eq("arst_weight_in", s_if.weight_in, 0);
        check_eq("arst_busy",      sm_busy,        0);
        check_eq("arst_done",      sm_done,        0);
        check_eq("arst_s_ready",   s_if.s_ready,   0);
        model_reset();
        s_if.s_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_obs();
        step(0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
        step(0, 0, 0, 0);
        check_mem("t5");

        // Random mix of starts, aborts, gaps and data.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);

        // 6: full-size load with random valid gaps.
        bg_start = 1'b1;
        @(posedge clk); #1;
        bg_start = 1'b0;
        bbeats = 0;
        cyc    = 0;
        while (bbeats < int'(BIG_TOTAL) && cyc < 60000) begin
            b_if.s_valid = ($urandom_range(0, 3) != 0);
            b_if.s_data  = 16'($urandom);
            @(posedge clk);
            if (b_if.s_valid) begin
                bdata[bbeats] = b_if.s_data;
                bbeats++;
            end
            #1;
            cyc++;
        end
        b_if.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("big_beats",  bbeats,    BIG_TOTAL);
        check_eq("big_writes", bwrites,   BIG_TOTAL);
        check_eq("big_done",   bdone_cnt, 1);
        check_eq("big_errs",   b_errs,    0);
        check_eq("big_busy",   bg_busy,   0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
